// File: rtl/exec_predict_unit.sv
// exec_predict_unit: ALU control decode, 32-bit combinational ALU and a
// direct-mapped branch target buffer (BTB) feeding the fetch PC mux.
// Optional feature macro: BTB_GSHARE_EN. When it is defined, the BTB index is
// XORed with the zero-extended global history. The tag compare always uses the
// full PC+4.
module exec_predict_unit #(
    parameter int BTB_ENTRIES = 8,
    parameter int IDX_W       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  aluop,
    input  logic [5:0]  funct,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    output logic [3:0]  aluctl,
    output logic [31:0] alu_out,
    output logic        zero,
    input  logic [31:0] pc4,
    output logic        hit,
    output logic        pred,
    output logic [31:0] target,
    input  logic [31:0] pc4_d,
    input  logic        wr_t,
    input  logic        wr_p,
    input  logic [31:0] target_in,
    input  logic        pred_in,
    input  logic [1:0]  ghist
);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_XOR = 4'b1101;

    // BTB storage, one element per entry
    logic              valid_q [BTB_ENTRIES];
    logic [31:0]       tag_q   [BTB_ENTRIES];
    logic [31:0]       tgt_q   [BTB_ENTRIES];
    logic              pred_q  [BTB_ENTRIES];

    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              rd_hit;
    logic              wr_p_hit;

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    // Decode main-control aluop plus funct into the ALU operation code
    always_comb begin
        aluctl = CTL_ADD;
        case (aluop)
            2'b01: aluctl = CTL_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: aluctl = CTL_ADD;
                    6'b100010: aluctl = CTL_SUB;
                    6'b100100: aluctl = CTL_AND;
                    6'b100101: aluctl = CTL_OR;
                    6'b100110: aluctl = CTL_XOR;
                    6'b100111: aluctl = CTL_NOR;
                    6'b101010: aluctl = CTL_SLT;
                    default:   aluctl = CTL_AND;
                endcase
            end
            default: aluctl = CTL_ADD;
        endcase
    end

    assign a_s = alu_a;
    assign b_s = alu_b;

    // ALU datapath; add/sub wrap modulo 2^32, unused codes produce zero
    always_comb begin
        alu_out = 32'd0;
        case (aluctl)
            CTL_AND: alu_out = alu_a & alu_b;
            CTL_OR:  alu_out = alu_a | alu_b;
            CTL_ADD: alu_out = alu_a + alu_b;
            CTL_SUB: alu_out = alu_a - alu_b;
            CTL_SLT: alu_out = (a_s < b_s) ? 32'd1 : 32'd0;
            CTL_NOR: alu_out = ~(alu_a | alu_b);
            CTL_XOR: alu_out = alu_a ^ alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    assign zero = (alu_out == 32'd0);

`ifdef BTB_GSHARE_EN
    // Hash the global history into the low index bits for both lookup and update
    assign rd_idx = pc4[IDX_W+1:2]   ^ IDX_W'(ghist);
    assign wr_idx = pc4_d[IDX_W+1:2] ^ IDX_W'(ghist);
`else
    logic unused_ghist;
    assign unused_ghist = ^ghist;
    assign rd_idx = pc4[IDX_W+1:2];
    assign wr_idx = pc4_d[IDX_W+1:2];
`endif

    // Zero-latency lookup; a miss forces pred and target to zero
    always_comb begin
        rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == pc4);
        hit    = rd_hit;
        pred   = rd_hit ? pred_q[rd_idx] : 1'b0;
        target = rd_hit ? tgt_q[rd_idx]  : 32'd0;
    end

    assign wr_p_hit = valid_q[wr_idx] && (tag_q[wr_idx] == pc4_d);

    // BTB update: reset clears everything, allocation beats a prediction update,
    // and a prediction update only touches an entry that matches the key
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < BTB_ENTRIES; e++) begin
                valid_q[e] <= 1'b0;
                tag_q[e]   <= 32'd0;
                tgt_q[e]   <= 32'd0;
                pred_q[e]  <= 1'b0;
            end
        end else if (wr_t) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= pc4_d;
            tgt_q[wr_idx]   <= target_in;
            pred_q[wr_idx]  <= pred_in;
        end else if (wr_p && wr_p_hit) begin
            pred_q[wr_idx]  <= pred_in;
        end
    end

endmodule

// File: tb/tb_exec_predict_unit.sv
// Directed testbench for exec_predict_unit (ALU decode/datapath and BTB).
module tb_exec_predict_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  aluctl;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] pc4;
    logic        hit;
    logic        pred;
    logic [31:0] target;
    logic [31:0] pc4_d;
    logic        wr_t;
    logic        wr_p;
    logic [31:0] target_in;
    logic        pred_in;
    logic [1:0]  ghist;

    int checks;
    int errors;

    exec_predict_unit dut (
        .clk       (clk),
        .reset     (reset),
        .aluop     (aluop),
        .funct     (funct),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .aluctl    (aluctl),
        .alu_out   (alu_out),
        .zero      (zero),
        .pc4       (pc4),
        .hit       (hit),
        .pred      (pred),
        .target    (target),
        .pc4_d     (pc4_d),
        .wr_t      (wr_t),
        .wr_p      (wr_p),
        .target_in (target_in),
        .pred_in   (pred_in),
        .ghist     (ghist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic eh, input logic ep, input logic [31:0] et);
        pc4 = pc;
        #1;
        checks++;
        if (hit !== eh || pred !== ep || target !== et) begin
            errors++;
            $display("FAIL %s: pc4=%h got hit=%b pred=%b target=%h expected hit=%b pred=%b target=%h",
                     name, pc, hit, pred, target, eh, ep, et);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; wr_t = 1'b0; wr_p = 1'b0;
        tick(); tick();
        reset = 1'b0;
        lookup("reset_lookup_10", 32'h10, 1'b0, 1'b0, 32'h0);
        lookup("reset_lookup_0",  32'h0,  1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_aluctl;
        logic [1:0]  ops [10] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [5:0]  fns [10] = '{6'h2A, 6'h24, 6'h20, 6'b100000, 6'b100010, 6'b100100,
                                  6'b100101, 6'b100110, 6'b100111, 6'b100001};
        logic [3:0]  exp [10] = '{4'b0010, 4'b0010, 4'b0110, 4'b0010, 4'b0110, 4'b0000,
                                  4'b0001, 4'b1101, 4'b1100, 4'b0000};
        for (int k = 0; k < 10; k++) begin
            aluop = ops[k]; funct = fns[k];
            #1;
            checks++;
            if (aluctl !== exp[k]) begin
                errors++;
                $display("FAIL aluctl[%0d]: aluop=%b funct=%b got %b expected %b",
                         k, ops[k], fns[k], aluctl, exp[k]);
            end
        end
    endtask

    task automatic test_alu;
        logic [1:0]  ops [11] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10,
                                  2'b01, 2'b11, 2'b10};
        logic [5:0]  fns [11] = '{6'b101010, 6'b101010, 6'h00, 6'h00, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'h00, 6'h00, 6'b111111};
        logic [31:0] as  [11] = '{32'hFFFFFFFF, 32'h5, 32'h7, 32'hFFFFFFFF, 32'hF0F0F0F0,
                                  32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h5, 32'h2,
                                  32'hFFFF0000};
        logic [31:0] bs  [11] = '{32'h1, 32'hFFFFFFFB, 32'h7, 32'h1, 32'hFF00FF00, 32'hFF00FF00,
                                  32'hFF00FF00, 32'hFF00FF00, 32'h7, 32'h3, 32'h0FF0FFFF};
        logic [31:0] res [11] = '{32'h1, 32'h0, 32'h0, 32'h0, 32'hF000F000, 32'hFFF0FFF0,
                                  32'h0FF00FF0, 32'h000F000F, 32'hFFFFFFFE, 32'h5, 32'h0FF00000};
        for (int k = 0; k < 11; k++) begin
            aluop = ops[k]; funct = fns[k]; alu_a = as[k]; alu_b = bs[k];
            #1;
            checks++;
            if (alu_out !== res[k] || zero !== (res[k] == 32'h0)) begin
                errors++;
                $display("FAIL alu[%0d]: a=%h b=%h got out=%h zero=%b expected out=%h zero=%b",
                         k, as[k], bs[k], alu_out, zero, res[k], (res[k] == 32'h0));
            end
        end
    endtask

    task automatic test_btb_alloc;
        pc4_d = 32'h10; target_in = 32'h40; pred_in = 1'b1; wr_t = 1'b1;
        tick();
        wr_t = 1'b0;
        lookup("alloc_10", 32'h10, 1'b1, 1'b1, 32'h40);
        lookup("alloc_other_tag_30", 32'h30, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wr_p;
        pc4_d = 32'h10; pred_in = 1'b0; wr_p = 1'b1;
        tick();
        wr_p = 1'b0;
        lookup("wr_p_clear", 32'h10, 1'b1, 1'b0, 32'h40);
        pc4_d = 32'h30; pred_in = 1'b1; wr_p = 1'b1;
        tick();
        wr_p = 1'b0;
        lookup("wr_p_tag_miss", 32'h10, 1'b1, 1'b0, 32'h40);
    endtask

    task automatic test_evict;
        pc4_d = 32'h30; target_in = 32'h80; pred_in = 1'b1; wr_t = 1'b1;
        tick();
        wr_t = 1'b0;
        lookup("evict_old_10", 32'h10, 1'b0, 1'b0, 32'h0);
        lookup("evict_new_30", 32'h30, 1'b1, 1'b1, 32'h80);
    endtask

    task automatic test_wt_wins;
        pc4_d = 32'h10; target_in = 32'h44; pred_in = 1'b1; wr_t = 1'b1; wr_p = 1'b1;
        tick();
        wr_t = 1'b0; wr_p = 1'b0;
        lookup("wt_wp_same_cycle", 32'h10, 1'b1, 1'b1, 32'h44);
    endtask

    task automatic test_back_to_back;
        // lookup before the edge sees old data, after the edge sees new data
        pc4_d = 32'h10; target_in = 32'h1234; pred_in = 1'b0; wr_t = 1'b1;
        lookup("rw_same_pre_edge", 32'h10, 1'b1, 1'b1, 32'h44);
        tick();
        pc4_d = 32'h24; target_in = 32'h200; pred_in = 1'b1;
        lookup("rw_same_post_edge", 32'h10, 1'b1, 1'b0, 32'h1234);
        tick();
        wr_t = 1'b0;
        lookup("b2b_second_entry", 32'h24, 1'b1, 1'b1, 32'h200);
        lookup("b2b_first_kept", 32'h10, 1'b1, 1'b0, 32'h1234);
    endtask

    task automatic test_reset_priority;
        reset = 1'b1; pc4_d = 32'h8; target_in = 32'h99; pred_in = 1'b1; wr_t = 1'b1;
        tick();
        reset = 1'b0; wr_t = 1'b0;
        lookup("reset_beats_wr_t", 32'h8, 1'b0, 1'b0, 32'h0);
        lookup("reset_clears_10", 32'h10, 1'b0, 1'b0, 32'h0);
        lookup("reset_clears_24", 32'h24, 1'b0, 1'b0, 32'h0);
    endtask

`ifdef BTB_GSHARE_EN
    task automatic test_gshare;
        ghist = 2'b01;
        pc4_d = 32'h10; target_in = 32'h40; pred_in = 1'b1; wr_t = 1'b1;
        tick();
        wr_t = 1'b0;
        lookup("gshare_hit_gh01", 32'h10, 1'b1, 1'b1, 32'h40);
        ghist = 2'b00;
        lookup("gshare_miss_gh00", 32'h10, 1'b0, 1'b0, 32'h0);
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; aluop = 2'b00; funct = 6'h0; alu_a = 32'h0; alu_b = 32'h0;
        pc4 = 32'h0; pc4_d = 32'h0; wr_t = 1'b0; wr_p = 1'b0;
        target_in = 32'h0; pred_in = 1'b0; ghist = 2'b00;
        test_reset();
        test_aluctl();
        test_alu();
        test_btb_alloc();
        test_wr_p();
        test_evict();
        test_wt_wins();
        test_back_to_back();
        test_reset_priority();
`ifdef BTB_GSHARE_EN
        test_gshare();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
